// File: rtl/rstmgr_pkg.sv
// Shared types for the reset sequencer: FSM states and reset-cause encoding.
package rstmgr_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    STRETCH   = 2'd1,
    CORE_WAIT = 2'd2,
    RUN       = 2'd3
  } rstmgr_state_e;

  typedef enum logic [1:0] {
    RST_CAUSE_EXT = 2'b01,
    RST_CAUSE_SW  = 2'b10
  } rst_cause_e;

endpackage

// File: rtl/rstmgr_seq_if.sv
// Software reset handshake, domain reset outputs and debug state of rstmgr_seq.
interface rstmgr_seq_if;
  import rstmgr_pkg::*;

  // sw_rst_req_i is a level request sampled on clk_i; it is accepted only in RUN,
  // where sw_rst_ack_o pulses high for the one cycle after the accepting edge.
  // The requester drops the request after seeing the ack, otherwise it is
  // accepted again the next time RUN is entered.
  logic          sw_rst_req_i;
  logic          sw_rst_ack_o;
  logic          rst_periph_no;
  logic          rst_core_no;
  logic [1:0]    rst_cause_o;
  logic          rst_active_o;
  rstmgr_state_e state_dbg;

  modport slave (
    input  sw_rst_req_i,
    output sw_rst_ack_o,
    output rst_periph_no,
    output rst_core_no,
    output rst_cause_o,
    output rst_active_o,
    output state_dbg
  );

  modport master (
    output sw_rst_req_i,
    input  sw_rst_ack_o,
    input  rst_periph_no,
    input  rst_core_no,
    input  rst_cause_o,
    input  rst_active_o,
    input  state_dbg
  );

endinterface

// File: rtl/rstmgr_sync.sv
// Async-assert / sync-deassert flop chain; reusable for any reset domain.
module rstmgr_sync #(
  parameter int SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_sync_o
);

  (* async_reg = "true" *) logic [SyncStages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], 1'b1};
    end
  end

  assign rst_sync_o = sync_q[SyncStages-1];

endmodule

// File: rtl/rstmgr_seq.sv
// Reset sequencer: releases peripheral then core reset with stretched,
// synchronised deassertion, and handles software-requested resets.
module rstmgr_seq
  import rstmgr_pkg::*;
#(
  parameter int SyncStages      = 2,
  parameter int StretchCycles   = 16,
  parameter int CoreDelayCycles = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  rstmgr_seq_if.slave rst_if
);

  localparam int MaxCycles = (StretchCycles > CoreDelayCycles) ? StretchCycles : CoreDelayCycles;
  localparam int CntW      = $clog2(MaxCycles) + 1;
  localparam logic [CntW-1:0] StretchLast = CntW'(StretchCycles - 1);
  localparam logic [CntW-1:0] CoreLast    = CntW'(CoreDelayCycles - 1);

  logic          rst_sync;
  rstmgr_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          periph_q, periph_d;
  logic          core_q, core_d;
  logic          ack_q, ack_d;
  logic          active_q, active_d;
  rst_cause_e    cause_q, cause_d;

  (* keep = "true", dont_touch = "true", keep_hierarchy = "yes" *)
  rstmgr_sync #(
    .SyncStages(SyncStages)
  ) u_sync (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rst_sync_o (rst_sync)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      ack_q    <= 1'b0;
      active_q <= 1'b1;
      cause_q  <= RST_CAUSE_EXT;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      core_q   <= core_d;
      ack_q    <= ack_d;
      active_q <= active_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    periph_d = periph_q;
    core_d   = core_q;
    ack_d    = 1'b0;
    cause_d  = cause_q;
    unique case (state_q)
      HOLD: begin
        cnt_d = '0;
        // The edge that first sees rst_sync high is already the first stretch
        // cycle, so the stretch is measured from the synchronised release.
        if (rst_sync) begin
          if (StretchCycles == 1) begin
            periph_d = 1'b1;
            state_d  = CORE_WAIT;
          end else begin
            cnt_d   = CntW'(1);
            state_d = STRETCH;
          end
        end
      end
      STRETCH: begin
        if (cnt_q == StretchLast) begin
          periph_d = 1'b1;
          cnt_d    = '0;
          state_d  = CORE_WAIT;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      CORE_WAIT: begin
        if (cnt_q == CoreLast) begin
          core_d  = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RUN: begin
        if (rst_if.sw_rst_req_i) begin
          periph_d = 1'b0;
          core_d   = 1'b0;
          ack_d    = 1'b1;
          cause_d  = RST_CAUSE_SW;
          cnt_d    = '0;
          state_d  = STRETCH;
        end
      end
      default: state_d = HOLD;
    endcase
    active_d = !(periph_d && core_d);
  end

  assign rst_if.rst_periph_no = periph_q;
  assign rst_if.rst_core_no   = core_q;
  assign rst_if.sw_rst_ack_o  = ack_q;
  assign rst_if.rst_active_o  = active_q;
  assign rst_if.rst_cause_o   = cause_q;
  assign rst_if.state_dbg     = state_q;

endmodule

// File: tb/tb_rstmgr_seq.sv
// Bench for rstmgr_seq: default-parameter instance plus a 3/1/1 instance.
module tb_rstmgr_seq;
  import rstmgr_pkg::*;

  localparam int SA  = 2;
  localparam int STA = 16;
  localparam int CA  = 8;
  localparam int PA  = SA + STA;
  localparam int KA  = SA + STA + CA;
  localparam int SB  = 3;
  localparam int STB = 1;
  localparam int CB  = 1;
  localparam int PB  = SB + STB;
  localparam int KB  = SB + STB + CB;
  localparam int B2B = STA + CA + 1;

  // clock / reset
  logic clk     = 1'b0;
  logic rst_n_a = 1'b1;
  logic rst_n_b = 1'b1;
  always #5 clk = ~clk;

  rstmgr_seq_if if_a ();
  rstmgr_seq_if if_b ();

  rstmgr_seq #(.SyncStages(SA), .StretchCycles(STA), .CoreDelayCycles(CA)) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n_a),
    .rst_if (if_a)
  );

  rstmgr_seq #(.SyncStages(SB), .StretchCycles(STB), .CoreDelayCycles(CB)) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n_b),
    .rst_if (if_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_a_q[$];
  logic [5:0] exp_b_q[$];
  logic [5:0] exp_w;

  wire [5:0] obs_a = {if_a.rst_periph_no, if_a.rst_core_no, if_a.sw_rst_ack_o,
                      if_a.rst_active_o, if_a.rst_cause_o};
  wire [5:0] obs_b = {if_b.rst_periph_no, if_b.rst_core_no, if_b.sw_rst_ack_o,
                      if_b.rst_active_o, if_b.rst_cause_o};

  // {periph_n, core_n, ack, active, cause}
  function automatic logic [5:0] mk(bit p, bit c, bit a, logic [1:0] cause);
    return {p, c, a, ~(p & c), cause};
  endfunction

  // rise-order monitor: core must never rise unless periph was already released
  logic pa_prev = 1'b0, ca_prev = 1'b0, pb_prev = 1'b0, cb_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    n_checks += 2;
    if (if_a.rst_core_no && !ca_prev && (!pa_prev || !if_a.rst_periph_no)) begin
      n_fail++;
      $display("FAIL rise_order_a t=%0t periph prev/now=%b/%b core now=%b, required periph released before core",
               $time, pa_prev, if_a.rst_periph_no, if_a.rst_core_no);
    end
    if (if_b.rst_core_no && !cb_prev && (!pb_prev || !if_b.rst_periph_no)) begin
      n_fail++;
      $display("FAIL rise_order_b t=%0t periph prev/now=%b/%b core now=%b, required periph released before core",
               $time, pb_prev, if_b.rst_periph_no, if_b.rst_core_no);
    end
    pa_prev = if_a.rst_periph_no;
    ca_prev = if_a.rst_core_no;
    pb_prev = if_b.rst_periph_no;
    cb_prev = if_b.rst_core_no;
  end

  // driver tasks
  task release_a();
    @(negedge clk);
    rst_n_a = 1'b1;
  endtask

  task release_b();
    @(negedge clk);
    rst_n_b = 1'b1;
  endtask

  task push_power_on_a(int n);
    for (int e = 1; e <= n; e++) exp_a_q.push_back(mk(e >= PA, e >= KA, 1'b0, RST_CAUSE_EXT));
  endtask

  task test_reset();
    if_a.sw_rst_req_i = 1'b0;
    if_b.sw_rst_req_i = 1'b0;
    #2;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    #1;
    exp_a_q.push_back(mk(0, 0, 0, RST_CAUSE_EXT));
    exp_b_q.push_back(mk(0, 0, 0, RST_CAUSE_EXT));
    exp_w = exp_a_q.pop_front();
    n_checks++;
    if (obs_a !== exp_w) begin
      n_fail++;
      $display("FAIL reset_a got=%b exp=%b", obs_a, exp_w);
    end
    exp_w = exp_b_q.pop_front();
    n_checks++;
    if (obs_b !== exp_w) begin
      n_fail++;
      $display("FAIL reset_b got=%b exp=%b", obs_b, exp_w);
    end
    repeat (3) @(posedge clk);
    #1;
    exp_a_q.push_back(mk(0, 0, 0, RST_CAUSE_EXT));
    exp_w = exp_a_q.pop_front();
    n_checks++;
    if (obs_a !== exp_w) begin
      n_fail++;
      $display("FAIL reset_held_a got=%b exp=%b", obs_a, exp_w);
    end
    n_checks++;
    if (if_a.state_dbg !== HOLD) begin
      n_fail++;
      $display("FAIL reset_state_a got=%0d exp=%0d", if_a.state_dbg, HOLD);
    end
  endtask

  task test_power_on();
    release_a();
    push_power_on_a(30);
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      exp_w = exp_a_q.pop_front();
      n_checks++;
      if (obs_a !== exp_w) begin
        n_fail++;
        $display("FAIL power_on edge=%0d got=%b exp=%b", e, obs_a, exp_w);
      end
    end
    n_checks++;
    if (if_a.state_dbg !== RUN) begin
      n_fail++;
      $display("FAIL power_on_state got=%0d exp=%0d", if_a.state_dbg, RUN);
    end
  endtask

  task test_sw_reset();
    if_a.sw_rst_req_i = 1'b1;
    for (int j = 0; j < 30; j++)
      exp_a_q.push_back(mk(j >= STA, j >= STA + CA, j == 0, RST_CAUSE_SW));
    for (int j = 0; j < 30; j++) begin
      @(posedge clk);
      #1;
      if (j == 0) if_a.sw_rst_req_i = 1'b0;
      exp_w = exp_a_q.pop_front();
      n_checks++;
      if (obs_a !== exp_w) begin
        n_fail++;
        $display("FAIL sw_reset k+%0d got=%b exp=%b", j, obs_a, exp_w);
      end
    end
  endtask

  task test_back_to_back();
    if_a.sw_rst_req_i = 1'b1;
    for (int j = 0; j < 2 * B2B; j++) begin
      int d;
      d = (j >= B2B) ? j - B2B : j;
      exp_a_q.push_back(mk(d >= STA, d >= STA + CA, d == 0, RST_CAUSE_SW));
    end
    for (int j = 0; j < 2 * B2B; j++) begin
      @(posedge clk);
      #1;
      if (j == B2B) if_a.sw_rst_req_i = 1'b0;
      exp_w = exp_a_q.pop_front();
      n_checks++;
      if (obs_a !== exp_w) begin
        n_fail++;
        $display("FAIL back_to_back k+%0d got=%b exp=%b", j, obs_a, exp_w);
      end
    end
  endtask

  task test_req_during_seq();
    #2;
    rst_n_a = 1'b0;
    #1;
    exp_a_q.push_back(mk(0, 0, 0, RST_CAUSE_EXT));
    exp_w = exp_a_q.pop_front();
    n_checks++;
    if (obs_a !== exp_w) begin
      n_fail++;
      $display("FAIL req_seq_reset got=%b exp=%b", obs_a, exp_w);
    end
    release_a();
    push_power_on_a(30);
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (e == 4) if_a.sw_rst_req_i = 1'b1;
      if (e == 20) if_a.sw_rst_req_i = 1'b0;
      exp_w = exp_a_q.pop_front();
      n_checks++;
      if (obs_a !== exp_w) begin
        n_fail++;
        $display("FAIL req_during_seq edge=%0d got=%b exp=%b", e, obs_a, exp_w);
      end
    end
  endtask

  task test_async_mid();
    #2;
    rst_n_a = 1'b0;
    #1;
    exp_a_q.push_back(mk(0, 0, 0, RST_CAUSE_EXT));
    exp_w = exp_a_q.pop_front();
    n_checks++;
    if (obs_a !== exp_w) begin
      n_fail++;
      $display("FAIL async_run got=%b exp=%b", obs_a, exp_w);
    end
    release_a();
    push_power_on_a(20);
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      exp_w = exp_a_q.pop_front();
      n_checks++;
      if (obs_a !== exp_w) begin
        n_fail++;
        $display("FAIL async_pre_core_wait edge=%0d got=%b exp=%b", e, obs_a, exp_w);
      end
    end
    n_checks++;
    if (if_a.state_dbg !== CORE_WAIT) begin
      n_fail++;
      $display("FAIL async_in_core_wait got=%0d exp=%0d", if_a.state_dbg, CORE_WAIT);
    end
    #2;
    rst_n_a = 1'b0;
    #1;
    exp_a_q.push_back(mk(0, 0, 0, RST_CAUSE_EXT));
    exp_w = exp_a_q.pop_front();
    n_checks++;
    if (obs_a !== exp_w) begin
      n_fail++;
      $display("FAIL async_core_wait got=%b exp=%b", obs_a, exp_w);
    end
    release_a();
    push_power_on_a(30);
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      exp_w = exp_a_q.pop_front();
      n_checks++;
      if (obs_a !== exp_w) begin
        n_fail++;
        $display("FAIL async_restart1 edge=%0d got=%b exp=%b", e, obs_a, exp_w);
      end
    end
    if_a.sw_rst_req_i = 1'b1;
    for (int j = 0; j < 5; j++)
      exp_a_q.push_back(mk(0, 0, j == 0, RST_CAUSE_SW));
    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      #1;
      if (j == 0) if_a.sw_rst_req_i = 1'b0;
      exp_w = exp_a_q.pop_front();
      n_checks++;
      if (obs_a !== exp_w) begin
        n_fail++;
        $display("FAIL async_sw_start k+%0d got=%b exp=%b", j, obs_a, exp_w);
      end
    end
    #2;
    rst_n_a = 1'b0;
    #1;
    exp_a_q.push_back(mk(0, 0, 0, RST_CAUSE_EXT));
    exp_w = exp_a_q.pop_front();
    n_checks++;
    if (obs_a !== exp_w) begin
      n_fail++;
      $display("FAIL async_during_sw got=%b exp=%b", obs_a, exp_w);
    end
    release_a();
    push_power_on_a(30);
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      exp_w = exp_a_q.pop_front();
      n_checks++;
      if (obs_a !== exp_w) begin
        n_fail++;
        $display("FAIL async_restart2 edge=%0d got=%b exp=%b", e, obs_a, exp_w);
      end
    end
  endtask

  task test_glitch();
    #1;
    rst_n_a = 1'b0;
    #1;
    exp_a_q.push_back(mk(0, 0, 0, RST_CAUSE_EXT));
    exp_w = exp_a_q.pop_front();
    n_checks++;
    if (obs_a !== exp_w) begin
      n_fail++;
      $display("FAIL glitch_assert got=%b exp=%b", obs_a, exp_w);
    end
    #1;
    rst_n_a = 1'b1;
    push_power_on_a(30);
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      exp_w = exp_a_q.pop_front();
      n_checks++;
      if (obs_a !== exp_w) begin
        n_fail++;
        $display("FAIL glitch_release edge=%0d got=%b exp=%b", e, obs_a, exp_w);
      end
    end
  endtask

  task test_sweep();
    release_b();
    for (int e = 1; e <= 8; e++)
      exp_b_q.push_back(mk(e >= PB, e >= KB, 1'b0, RST_CAUSE_EXT));
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      exp_w = exp_b_q.pop_front();
      n_checks++;
      if (obs_b !== exp_w) begin
        n_fail++;
        $display("FAIL sweep_power_on edge=%0d got=%b exp=%b", e, obs_b, exp_w);
      end
    end
    if_b.sw_rst_req_i = 1'b1;
    for (int j = 0; j < 6; j++)
      exp_b_q.push_back(mk(j >= STB, j >= STB + CB, j == 0, RST_CAUSE_SW));
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      if (j == 0) if_b.sw_rst_req_i = 1'b0;
      exp_w = exp_b_q.pop_front();
      n_checks++;
      if (obs_b !== exp_w) begin
        n_fail++;
        $display("FAIL sweep_sw_reset k+%0d got=%b exp=%b", j, obs_b, exp_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_sw_reset();
    test_back_to_back();
    test_req_during_seq();
    test_async_mid();
    test_glitch();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
